// File: rtl/leaf_out_stream_arbiter_if.sv
// Output-stream bundle between user kernel output ports, the arbiter and the leaf interface.
// The arbiter takes the master view; the surrounding logic or bench takes the slave view.
interface leaf_out_stream_arbiter_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_PORTS     = 4,
  parameter int NUM_PORT_BITS = 4
);
  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user2arb;
  logic [NUM_PORTS-1:0]              vld_user2arb;
  logic [NUM_PORTS-1:0]              ack_arb2user;
  logic [PAYLOAD_BITS-1:0]           dout_arb2interface;
  logic [NUM_PORT_BITS-1:0]          port_arb2interface;
  logic                              vld_arb2interface;
  logic                              ack_interface2arb;
  logic [NUM_PORTS-1:0]              credit_return;
  logic                              credit_ovf;

  modport master (
    input  din_user2arb, vld_user2arb, ack_interface2arb, credit_return,
    output ack_arb2user, dout_arb2interface, port_arb2interface, vld_arb2interface, credit_ovf
  );

  modport slave (
    output din_user2arb, vld_user2arb, ack_interface2arb, credit_return,
    input  ack_arb2user, dout_arb2interface, port_arb2interface, vld_arb2interface, credit_ovf
  );
endinterface

// File: rtl/leaf_out_stream_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one leaf output stream among NUM_PORTS user
// ports, tagging each word with its source port and gating each port on remote credit.
module leaf_out_stream_arbiter #(
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_PORTS             = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int CREDIT_BITS           = 8,
  parameter int INIT_CREDIT           = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int BURST_LEN             = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  leaf_out_stream_arbiter_if.master  bus
);
  localparam int PTR_W   = $clog2(NUM_PORTS);
  localparam int BURST_W = $clog2(BURST_LEN + 1);
  localparam int SUM_W   = 32;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]        grant, grant_nxt;
  logic [BURST_W-1:0]      burst_cnt, burst_cnt_nxt;
  logic [CREDIT_BITS-1:0]  credit     [NUM_PORTS];
  logic [CREDIT_BITS-1:0]  credit_nxt [NUM_PORTS];
  logic [NUM_PORTS-1:0]    sat_hit;
  logic [NUM_PORTS-1:0]    eligible;
  logic [NUM_PORTS-1:0]    ack_p0;
  logic                    ack_ok_p0;
  logic                    xfer_p0;
  logic                    pick_vld;
  logic [PTR_W-1:0]        pick;
  logic [PTR_W:0]          pick_idx;
  logic [PAYLOAD_BITS-1:0] din_sel_p0;
  logic [PAYLOAD_BITS-1:0] data_p1;
  logic [NUM_PORT_BITS-1:0] port_p1;
  logic                    vld_p1;
  logic                    ovf;

  function automatic logic [SUM_W-1:0] credit_sum(input logic [CREDIT_BITS-1:0] cur,
                                                  input logic inc, input logic dec);
    return SUM_W'(cur) + (inc ? SUM_W'(FREESPACE_UPDATE_SIZE) : '0) - (dec ? SUM_W'(1) : '0);
  endfunction

  function automatic logic [CREDIT_BITS-1:0] sat_credit(input logic [SUM_W-1:0] sum);
    return (sum > SUM_W'(CREDIT_MAX)) ? CREDIT_MAX : sum[CREDIT_BITS-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = bus.vld_user2arb[i] && (credit[i] != '0);
    end
  end

  // Search starts one past the last granted port so every port gets its turn.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      pick_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pick_idx >= (PTR_W+1)'(NUM_PORTS)) pick_idx = pick_idx - (PTR_W+1)'(NUM_PORTS);
      if (!pick_vld && eligible[pick_idx[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = pick_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    din_sel_p0 = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == PTR_W'(i)) din_sel_p0 = bus.din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Stage p0: grant FSM and handshake toward the user ports.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant;
    burst_cnt_nxt = burst_cnt;
    ack_p0        = '0;
    ack_ok_p0     = 1'b0;
    xfer_p0       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        ack_ok_p0     = (!vld_p1 || bus.ack_interface2arb) && (credit[grant] != '0)
                        && (burst_cnt < BURST_W'(BURST_LEN));
        ack_p0[grant] = ack_ok_p0;
        xfer_p0       = ack_ok_p0 && bus.vld_user2arb[grant];
        if (xfer_p0) burst_cnt_nxt = burst_cnt + 1'b1;
        // A simultaneous credit_return keeps the credit above zero, so it does not end the burst.
        if ((xfer_p0 && ((burst_cnt_nxt == BURST_W'(BURST_LEN)) ||
                         ((credit[grant] == CREDIT_BITS'(1)) && !bus.credit_return[grant]))) ||
            (ack_ok_p0 && !bus.vld_user2arb[grant])) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_nxt[i] = sat_credit(credit_sum(credit[i], bus.credit_return[i],
                                            xfer_p0 && (grant == PTR_W'(i))));
      sat_hit[i]    = credit_sum(credit[i], bus.credit_return[i], 1'b0) > SUM_W'(CREDIT_MAX);
    end
  end

  // Stage p1: registered output word, held while the interface stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_PORTS - 1);
      grant     <= '0;
      burst_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) credit[i] <= CREDIT_BITS'(INIT_CREDIT);
      data_p1   <= '0;
      port_p1   <= '0;
      vld_p1    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant     <= grant_nxt;
      burst_cnt <= burst_cnt_nxt;
      for (int i = 0; i < NUM_PORTS; i++) credit[i] <= credit_nxt[i];
      if (|sat_hit) ovf <= 1'b1;
      if (xfer_p0) begin
        data_p1 <= din_sel_p0;
        port_p1 <= NUM_PORT_BITS'(grant);
        vld_p1  <= 1'b1;
      end else if (bus.ack_interface2arb) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.ack_arb2user       = ack_p0;
  assign bus.dout_arb2interface = data_p1;
  assign bus.port_arb2interface = port_p1;
  assign bus.vld_arb2interface  = vld_p1;
  assign bus.credit_ovf         = ovf;
endmodule
